// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial adder/subtractor: one full adder stepped LSB-first over WIDTH cycles.
// Optional signed-overflow output ovf_o is enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_add_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic [1:0]       dbg_state_o
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int IDXW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             carry_q, cout_q;
  logic [IDXW-1:0]  idx_q;
  logic             bit_x, bit_y, bit_s, bit_c, last_bit;

  // Subtraction is a + ~b + 1: b is inverted at accept and the carry seeded with sub.
  assign bit_x    = a_q[idx_q];
  assign bit_y    = b_q[idx_q];
  assign bit_s    = bit_x ^ bit_y ^ carry_q;
  assign bit_c    = (bit_x & bit_y) | (bit_x & carry_q) | (bit_y & carry_q);
  assign last_bit = (idx_q == IDXW'(WIDTH - 1));

  always_comb begin
    sum_d        = sum_q;
    sum_d[idx_q] = bit_s;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q == RUN);
    done_o      = (state_q == DONE);
    dbg_state_o = state_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (state_q == IDLE && start_i) begin
      a_q     <= a_i;
      b_q     <= sub_i ? ~b_i : b_i;
      carry_q <= sub_i;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (state_q == RUN) begin
      sum_q   <= sum_d;
      carry_q <= bit_c;
      idx_q   <= last_bit ? '0 : idx_q + IDXW'(1);
      if (last_bit) cout_q <= bit_c;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q;

  // Carry into the MSB is carry_q on the final step; carry out is bit_c.
  always_ff @(posedge clk_i) begin
    if (rst_i)                              ovf_q <= 1'b0;
    else if (state_q == IDLE && start_i)    ovf_q <= 1'b0;
    else if (state_q == RUN && last_bit)    ovf_q <= carry_q ^ bit_c;
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Testbench for serial_add_sub_ctrl (WIDTH=8): vector table, random ops vs arithmetic model,
// continuous-start spacing and mid-run reset abort. Checks ovf when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_add_sub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic [1:0]   dbg_state;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // {ovf, cout, sum}
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  serial_add_sub_ctrl #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .sub_i       (sub),
    .a_i         (a),
    .b_i         (b),
    .busy_o      (busy),
    .done_o      (done),
    .sum_o       (sum),
    .cout_o      (cout),
    .dbg_state_o (dbg_state)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf_o       (ovf)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endfunction

  // Reference: plain integer arithmetic, modulo 2^W; cout = no borrow for subtract.
  function automatic logic [W+1:0] model(logic s, logic [W-1:0] x, logic [W-1:0] y);
    int ux, uy, sx, sy, ur, sr;
    logic [W-1:0] r;
    logic c, o;
    ux = int'(x); uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    if (s) begin
      ur = ux - uy; c = (ux >= uy); sr = sx - sy;
    end else begin
      ur = ux + uy; c = (ur > 255); sr = sx + sy;
    end
    r = W'(ur & 255);
    o = (sr < -128) || (sr > 127);
    return {o, c, r};
  endfunction

  // scoreboard: every done pulse must match the oldest accepted operation
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e[W-1:0]));
        check("cout", 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADDSUB_OVF_EN
        check("ovf", 32'(ovf), 32'(e[W+1]));
`endif
        check("busy_done_excl", 32'(busy), 32'd0);
      end
    end
  end

  // Called just after a negedge with DUT idle; returns just after the negedge following done.
  task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W+1:0] e);
    int busy_cnt;
    bit got;
    start = 1'b1; sub = s; a = x; b = y;
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    busy_cnt = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1;
      else begin
        if (busy) busy_cnt++;
        @(negedge clk);
      end
    end
    check("done_seen", 32'(got), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'd8);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("sum_held", 32'(sum), 32'(e[W-1:0]));
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);

    // first start accepted at first edge with rst low; then back-to-back vectors
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, {vecs[i].ovf, vecs[i].cout, vecs[i].sum});

    // randomized operations against the model
    for (int i = 0; i < 20; i++) begin
      logic s;
      logic [W-1:0] x, y;
      s = 1'($urandom_range(0, 1));
      x = W'($urandom_range(0, 255));
      y = W'($urandom_range(0, 255));
      run_op(s, x, y, model(s, x, y));
    end

    // start held high with changing operands: one accept every W+2 cycles
    for (int t = 0; t < 50; t++) begin
      logic s;
      logic [W-1:0] x, y;
      s = 1'($urandom); x = W'($urandom); y = W'($urandom);
      start = 1'b1; sub = s; a = x; b = y;
      @(posedge clk);
      if (t % 10 == 0) exp_q.push_back(model(s, x, y));
      @(negedge clk);
      check("cont_busy", 32'(busy), 32'((t % 10) < 8));
      check("cont_done", 32'(done), 32'((t % 10) == 8));
    end
    start = 1'b0;
    @(negedge clk);

    // reset on the 4th RUN cycle aborts without a done pulse
    begin
      bit saw_done;
      start = 1'b1; sub = 1'b0; a = 8'hA5; b = 8'h5A;
      @(negedge clk);
      start = 1'b0;
      check("abort_running", 32'(busy), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_cout", 32'(cout), 32'd0);
      saw_done = 0;
      for (int i = 0; i < 12; i++) begin
        if (done) saw_done = 1;
        @(negedge clk);
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
    end
    run_op(1'b1, 8'h3C, 8'h0F, model(1'b1, 8'h3C, 8'h0F));
    run_op(1'b0, 8'hC8, 8'h64, model(1'b0, 8'hC8, 8'h64));

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_add_sub_ctrl.md
SERIAL_ADD_SUB_CTRL -- requirements
Module: serial_add_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin one operation; sampled every edge.
REQ-005 sub  input  1  operation select: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 a  input  WIDTH  operand A, unsigned/two's complement; sampled with start.
REQ-007 b  input  WIDTH  operand B; sampled with start.
REQ-008 busy  output  1  high while bit-serial computation in progress.
REQ-009 done  output  1  single-cycle pulse marking result valid.
REQ-010 sum  output  WIDTH  result register, held until next accepted start.
REQ-011 cout  output  1  final carry; for subtract, 1 = no borrow, 0 = borrow.

Function
REQ-012 Block SHALL sequence a single 1-bit full adder (sum = x^y^c, carry = majority(x,y,c)) over WIDTH cycles, LSB first.
REQ-013 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge SHALL latch a, b (b inverted when sub=1), sub, set carry register = sub, bit index = 0, clear sum and cout, move to RUN.
REQ-015 start SHALL be ignored in RUN and DONE; no re-latch, no restart, no queuing.
REQ-016 RUN: each edge SHALL compute bit[index] from latched operands and carry register, write it into sum[index], update carry, increment index.
REQ-017 RUN SHALL last exactly WIDTH cycles; on the edge processing index WIDTH-1, state SHALL go to DONE and cout SHALL take the final carry.
REQ-018 DONE SHALL last exactly one cycle, then IDLE unconditionally.
REQ-019 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both registered-state decodes, never both high.
REQ-020 Latency: start accepted at edge E0 -> busy high cycles E0+1..E0+WIDTH -> done high for the cycle after edge E0+WIDTH; result stable from that cycle.
REQ-021 Minimum start-to-start spacing SHALL be WIDTH+2 cycles; start high in the IDLE cycle following DONE SHALL be accepted.
REQ-022 sum and cout SHALL be modified only in RUN (and cleared on accept or reset); otherwise held.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; carry out of MSB appears only on cout.
REQ-024 Operand input changes after acceptance SHALL not affect the running operation.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, carry=0, index=0, regardless of state.
REQ-026 rst SHALL take priority over start; reset mid-RUN SHALL abort with no done pulse.
REQ-027 First start after rst deasserts SHALL be accepted at the first edge with rst=0.

Configuration
REQ-028 Macro SERIAL_ADDSUB_OVF_EN: when defined, SHALL add output port ovf (1 bit) = signed overflow, i.e. carry-into-MSB XOR carry-out-of-MSB, written on the final RUN edge, cleared on accept/reset, held otherwise.
REQ-029 When SERIAL_ADDSUB_OVF_EN is undefined, port ovf and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-030 Reset, start=1 sub=0 a=0x3C b=0x0F -> busy 8 cycles, done pulse 1 cycle, sum=0x4B, cout=0.
REQ-031 sub=0 a=0xFF b=0x01 -> sum=0x00, cout=1; sub=1 a=0x05 b=0x07 -> sum=0xFE, cout=0; sub=1 a=0x07 b=0x05 -> sum=0x02, cout=1.
REQ-032 start held high continuously with changing a/b -> operations accepted only every 10 cycles, each result matching operands present at its accept edge.
REQ-033 rst asserted on 4th RUN cycle -> next cycle busy=0, done=0, sum=0x00, cout=0, no done pulse; subsequent start computes correctly.
REQ-034 With SERIAL_ADDSUB_OVF_EN: a=0x7F b=0x01 sub=0 -> sum=0x80, ovf=1; sub=1 a=0x80 b=0x01 -> sum=0x7F, ovf=1; a=0x10 b=0x20 sub=0 -> ovf=0.
